// File: rtl/lvl_states_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : lvl_states_arbiter_pkg                                        |
// | Desc   : Shared constants for the lvl-state BRAM arbiter: default word |
// |          and address widths, and the FSM state encoding.               |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
package lvl_states_arbiter_pkg;

  // Default lvl-state word width {dcd_bin, has_bkt} and BRAM address width.
  localparam int DEF_WIDTH_LVL_STATES      = 11;
  localparam int DEF_ADDR_WIDTH_LVL_STATES = 9;

  // Arbiter FSM encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_INIT  = 2'd0;
  localparam state_t ST_IDLE  = 2'd1;
  localparam state_t ST_GRANT = 2'd2;

endpackage : lvl_states_arbiter_pkg
`default_nettype wire

// File: rtl/lvl_states_arbiter_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : rr_pick                                                       |
// | Desc   : Combinational round-robin pick. Searches req_i upward with    |
// |          wrap, starting one past last_winner_i.                        |
// | Ports  : req_i         - request vector                                |
// |          last_winner_i - index of the previous winner                  |
// |          winner_o      - index of the selected requester               |
// |          valid_o       - at least one request is set                   |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_winner_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               valid_o
);

  int               sum;
  logic [IDX_W-1:0] cand;

  // Offsets 1..NUM_REQ visit every requester exactly once, the previous
  // winner last, so it only wins again when nobody else is asking.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    sum      = 0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum = int'(last_winner_i) + i;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      cand = IDX_W'(sum);
      if (!valid_o && req_i[cand]) begin
        valid_o  = 1'b1;
        winner_o = cand;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/lvl_states_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : lvl_states_arbiter                                            |
// | Desc   : Round-robin arbiter sharing one lvl-state BRAM port pair      |
// |          between NUM_REQ requesters. The owner holds the grant while   |
// |          its apply_i stays high; writes from non-owners are dropped    |
// |          and latch the sticky conflict_o flag.                         |
// | Config : LVL_STATES_INIT_SWEEP_EN - clear the BRAM after reset by      |
// |          writing 0 to every address before arbitration starts.         |
// | Ports  : clk/rst      - clock, asynchronous active-low reset           |
// |          apply_i      - per-requester level hold request               |
// |          raddr_i/we_i/waddr_i/wdata_i - packed per-requester RAM ops   |
// |          grant_o      - registered one-hot grant                       |
// |          rdata_o      - RAM read data broadcast to all requesters      |
// |          ram_*        - BRAM port (1-cycle read latency)               |
// |          init_done_o  - BRAM valid, arbitration enabled                |
// |          conflict_o   - sticky: ungranted requester drove a write      |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module lvl_states_arbiter
  import lvl_states_arbiter_pkg::*;
#(
  parameter int WIDTH_LVL_STATES      = DEF_WIDTH_LVL_STATES,
  parameter int ADDR_WIDTH_LVL_STATES = DEF_ADDR_WIDTH_LVL_STATES,
  parameter int NUM_REQ               = 3
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0]                       apply_i,
  input  logic [NUM_REQ*ADDR_WIDTH_LVL_STATES-1:0] raddr_i,
  input  logic [NUM_REQ-1:0]                       we_i,
  input  logic [NUM_REQ*ADDR_WIDTH_LVL_STATES-1:0] waddr_i,
  input  logic [NUM_REQ*WIDTH_LVL_STATES-1:0]      wdata_i,
  output logic [NUM_REQ-1:0]                       grant_o,
  output logic [WIDTH_LVL_STATES-1:0]              rdata_o,
  output logic [ADDR_WIDTH_LVL_STATES-1:0]         ram_raddr_o,
  input  logic [WIDTH_LVL_STATES-1:0]              ram_rdata_i,
  output logic                                     ram_we_o,
  output logic [ADDR_WIDTH_LVL_STATES-1:0]         ram_waddr_o,
  output logic [WIDTH_LVL_STATES-1:0]              ram_wdata_o,
  output logic                                     init_done_o,
  output logic                                     conflict_o
);

  localparam int AW    = ADDR_WIDTH_LVL_STATES;
  localparam int WW    = WIDTH_LVL_STATES;
  localparam int IDX_W = $clog2(NUM_REQ);

  // INIT leaves after the last swept address, or after one post-reset
  // cycle when the sweep is compiled out.
`ifdef LVL_STATES_INIT_SWEEP_EN
  localparam logic [AW-1:0] INIT_LAST = '1;
`else
  localparam logic [AW-1:0] INIT_LAST = AW'(1);
`endif

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_winner_q, last_winner_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic               conflict_q, conflict_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i         (apply_i),
    .last_winner_i (last_winner_q),
    .winner_o      (pick_idx),
    .valid_o       (pick_valid)
  );

  // State register (plus the registered datapath that moves with it).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_INIT;
      grant_q       <= '0;
      last_winner_q <= IDX_W'(NUM_REQ - 1);
      cnt_q         <= '0;
      conflict_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_winner_q <= last_winner_d;
      cnt_q         <= cnt_d;
      conflict_q    <= conflict_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_winner_d = last_winner_q;
    cnt_d         = cnt_q;
    // grant_q is registered, so a requester whose apply_i rises in the
    // same cycle as its write is still seen as ungranted.
    conflict_d    = conflict_q | (|(we_i & ~grant_q));
    case (state_q)
      ST_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (pick_valid) begin
          state_d       = ST_GRANT;
          grant_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          last_winner_d = pick_idx;
        end
      end
      ST_GRANT: begin
        // Owner keeps the port until its own apply bit drops.
        if (!(|(apply_i & grant_q))) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: BRAM port mux.
  always_comb begin
    ram_we_o    = 1'b0;
    ram_raddr_o = '0;
    ram_waddr_o = '0;
    ram_wdata_o = '0;
    if (state_q == ST_INIT) begin
`ifdef LVL_STATES_INIT_SWEEP_EN
      // Gated by rst so the sweep never writes while reset is held.
      ram_we_o    = rst;
      ram_waddr_o = cnt_q;
`endif
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant_q[k]) begin
          ram_raddr_o = raddr_i[k*AW +: AW];
          ram_we_o    = we_i[k];
          ram_waddr_o = waddr_i[k*AW +: AW];
          ram_wdata_o = wdata_i[k*WW +: WW];
        end
      end
    end
  end

  assign grant_o     = grant_q;
  assign rdata_o     = ram_rdata_i;
  assign init_done_o = (state_q != ST_INIT);
  assign conflict_o  = conflict_q;

endmodule : lvl_states_arbiter
`default_nettype wire

// File: tb/tb_lvl_states_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_lvl_states_arbiter                                         |
// | Desc   : Directed bench for lvl_states_arbiter: cycle table for        |
// |          arbitration, port muxing and conflicts, plus hand sequences   |
// |          for init (sweep or one-cycle INIT) and mid-grant reset.       |
// |          Honours LVL_STATES_INIT_SWEEP_EN like the design.             |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_lvl_states_arbiter;

  localparam int AW = 4;
  localparam int WW = 11;
  localparam int NR = 3;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    apply_i;
  logic [NR*AW-1:0] raddr_i;
  logic [NR-1:0]    we_i;
  logic [NR*AW-1:0] waddr_i;
  logic [NR*WW-1:0] wdata_i;
  logic [NR-1:0]    grant_o;
  logic [WW-1:0]    rdata_o;
  logic [AW-1:0]    ram_raddr_o;
  logic [WW-1:0]    ram_rdata_i;
  logic             ram_we_o;
  logic [AW-1:0]    ram_waddr_o;
  logic [WW-1:0]    ram_wdata_o;
  logic             init_done_o;
  logic             conflict_o;

  lvl_states_arbiter #(
    .WIDTH_LVL_STATES      (WW),
    .ADDR_WIDTH_LVL_STATES (AW),
    .NUM_REQ               (NR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .apply_i     (apply_i),
    .raddr_i     (raddr_i),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .grant_o     (grant_o),
    .rdata_o     (rdata_o),
    .ram_raddr_o (ram_raddr_o),
    .ram_rdata_i (ram_rdata_i),
    .ram_we_o    (ram_we_o),
    .ram_waddr_o (ram_waddr_o),
    .ram_wdata_o (ram_wdata_o),
    .init_done_o (init_done_o),
    .conflict_o  (conflict_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BRAM, read-first, 1-cycle read latency.
  logic [WW-1:0] mem [1<<AW];
  always @(posedge clk) begin
    if (ram_we_o) mem[ram_waddr_o] <= ram_wdata_o;
    ram_rdata_i <= mem[ram_raddr_o];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"},     32'(grant_o), 32'd0);
    check({tag, "_we"},        32'(ram_we_o), 32'd0);
    check({tag, "_waddr"},     32'(ram_waddr_o), 32'd0);
    check({tag, "_wdata"},     32'(ram_wdata_o), 32'd0);
    check({tag, "_raddr"},     32'(ram_raddr_o), 32'd0);
    check({tag, "_conflict"},  32'(conflict_o), 32'd0);
    check({tag, "_init_done"}, 32'(init_done_o), 32'd0);
  endtask

  // Release reset at a falling edge and follow INIT to IDLE, with all
  // requesters asking throughout (they must be ignored).
  task automatic do_init();
    apply_i = '1; we_i = '0; raddr_i = '0; waddr_i = '0; wdata_i = '0;
    @(negedge clk);
    rst = 1'b1;
`ifdef LVL_STATES_INIT_SWEEP_EN
    for (int i = 0; i < (1 << AW); i++) begin
      #1;
      check("sweep_we",    32'(ram_we_o), 32'd1);
      check("sweep_waddr", 32'(ram_waddr_o), 32'(i));
      check("sweep_wdata", 32'(ram_wdata_o), 32'd0);
      check("init_grant",  32'(grant_o), 32'd0);
      check("init_done_lo", 32'(init_done_o), 32'd0);
      @(negedge clk);
    end
`else
    for (int i = 0; i < 2; i++) begin
      #1;
      check("init_we",     32'(ram_we_o), 32'd0);
      check("init_grant",  32'(grant_o), 32'd0);
      check("init_done_lo", 32'(init_done_o), 32'd0);
      @(negedge clk);
    end
`endif
    #1;
    check("init_done_hi", 32'(init_done_o), 32'd1);
    check("idle_grant",   32'(grant_o), 32'd0);
    check("idle_we",      32'(ram_we_o), 32'd0);
    apply_i = '0;
  endtask

  typedef struct {
    logic [NR-1:0]    apply;
    logic [NR-1:0]    we;
    logic [NR*AW-1:0] raddr;
    logic [NR*AW-1:0] waddr;
    logic [NR*WW-1:0] wdata;
    logic [NR-1:0]    e_grant;
    logic             e_we;
    logic [AW-1:0]    e_raddr;
    logic [AW-1:0]    e_waddr;
    logic [WW-1:0]    e_wdata;
    logic             e_conflict;
    logic             chk_rd;
    logic [WW-1:0]    e_rdata;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    //            apply   we      raddr    waddr    wdata                 grant   we    raddr waddr wdata   conf  chk   rdata
    vecs[0]  = '{3'b101, 3'b000, 12'h000, 12'h000, 33'h0,                3'b000, 1'b0, 4'd0, 4'd0, 11'h000, 1'b0, 1'b0, 11'h000};
    vecs[1]  = '{3'b101, 3'b000, 12'h003, 12'h000, 33'h0,                3'b001, 1'b0, 4'd3, 4'd0, 11'h000, 1'b0, 1'b0, 11'h000};
    vecs[2]  = '{3'b100, 3'b000, 12'h003, 12'h000, 33'h0,                3'b001, 1'b0, 4'd3, 4'd0, 11'h000, 1'b0, 1'b0, 11'h000};
    vecs[3]  = '{3'b100, 3'b000, 12'h000, 12'h000, 33'h0,                3'b000, 1'b0, 4'd0, 4'd0, 11'h000, 1'b0, 1'b0, 11'h000};
    vecs[4]  = '{3'b100, 3'b100, 12'h900, 12'h200, {11'h011, 22'h0},     3'b100, 1'b1, 4'd9, 4'd2, 11'h011, 1'b0, 1'b0, 11'h000};
    vecs[5]  = '{3'b000, 3'b000, 12'h000, 12'h000, 33'h0,                3'b100, 1'b0, 4'd0, 4'd0, 11'h000, 1'b0, 1'b0, 11'h000};
    vecs[6]  = '{3'b010, 3'b000, 12'h000, 12'h000, 33'h0,                3'b000, 1'b0, 4'd0, 4'd0, 11'h000, 1'b0, 1'b0, 11'h000};
    vecs[7]  = '{3'b010, 3'b010, 12'h050, 12'h050, {11'h0, 11'h02A, 11'h0}, 3'b010, 1'b1, 4'd5, 4'd5, 11'h02A, 1'b0, 1'b0, 11'h000};
    vecs[8]  = '{3'b010, 3'b000, 12'h050, 12'h000, 33'h0,                3'b010, 1'b0, 4'd5, 4'd0, 11'h000, 1'b0, 1'b0, 11'h000};
    vecs[9]  = '{3'b010, 3'b100, 12'h050, 12'h700, {11'h155, 22'h0},     3'b010, 1'b0, 4'd5, 4'd0, 11'h000, 1'b0, 1'b1, 11'h02A};
    vecs[10] = '{3'b010, 3'b000, 12'h050, 12'h000, 33'h0,                3'b010, 1'b0, 4'd5, 4'd0, 11'h000, 1'b1, 1'b1, 11'h02A};
    vecs[11] = '{3'b000, 3'b000, 12'h000, 12'h000, 33'h0,                3'b010, 1'b0, 4'd0, 4'd0, 11'h000, 1'b1, 1'b0, 11'h000};
    vecs[12] = '{3'b011, 3'b000, 12'h000, 12'h000, 33'h0,                3'b000, 1'b0, 4'd0, 4'd0, 11'h000, 1'b1, 1'b0, 11'h000};
    vecs[13] = '{3'b011, 3'b000, 12'h007, 12'h000, 33'h0,                3'b001, 1'b0, 4'd7, 4'd0, 11'h000, 1'b1, 1'b0, 11'h000};
    vecs[14] = '{3'b011, 3'b000, 12'h007, 12'h000, 33'h0,                3'b001, 1'b0, 4'd7, 4'd0, 11'h000, 1'b1, 1'b1, 11'h000};
    vecs[15] = '{3'b010, 3'b000, 12'h000, 12'h000, 33'h0,                3'b001, 1'b0, 4'd0, 4'd0, 11'h000, 1'b1, 1'b0, 11'h000};
    vecs[16] = '{3'b010, 3'b000, 12'h000, 12'h000, 33'h0,                3'b000, 1'b0, 4'd0, 4'd0, 11'h000, 1'b1, 1'b0, 11'h000};
    vecs[17] = '{3'b010, 3'b000, 12'h000, 12'h000, 33'h0,                3'b010, 1'b0, 4'd0, 4'd0, 11'h000, 1'b1, 1'b0, 11'h000};

    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    rst = 1'b0;
    apply_i = '0; we_i = '0; raddr_i = '0; waddr_i = '0; wdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_vals("rst");

    do_init();

    // Cycle table: drive after the falling edge, check 1 ns later.
    for (int v = 0; v < NV; v++) begin
      apply_i = vecs[v].apply;
      we_i    = vecs[v].we;
      raddr_i = vecs[v].raddr;
      waddr_i = vecs[v].waddr;
      wdata_i = vecs[v].wdata;
      #1;
      check($sformatf("v%0d_grant", v),    32'(grant_o),     32'(vecs[v].e_grant));
      check($sformatf("v%0d_we", v),       32'(ram_we_o),    32'(vecs[v].e_we));
      check($sformatf("v%0d_raddr", v),    32'(ram_raddr_o), 32'(vecs[v].e_raddr));
      check($sformatf("v%0d_waddr", v),    32'(ram_waddr_o), 32'(vecs[v].e_waddr));
      check($sformatf("v%0d_wdata", v),    32'(ram_wdata_o), 32'(vecs[v].e_wdata));
      check($sformatf("v%0d_conflict", v), 32'(conflict_o),  32'(vecs[v].e_conflict));
      if (vecs[v].chk_rd) begin
        check($sformatf("v%0d_rdata", v),  32'(rdata_o),     32'(vecs[v].e_rdata));
      end
      @(negedge clk);
    end

    // Mid-grant reset: requester 1 owns the port and is writing.
    apply_i = 3'b010;
    we_i    = 3'b010;
    raddr_i = '0;
    waddr_i = {4'd0, 4'd3, 4'd0};
    wdata_i = {11'h0, 11'h7FF, 11'h0};
    #1;
    check("pre_rst_grant", 32'(grant_o), 32'(3'b010));
    check("pre_rst_we",    32'(ram_we_o), 32'd1);
    check("pre_rst_waddr", 32'(ram_waddr_o), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_vals("held_rst");

    do_init();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d n_bad=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_lvl_states_arbiter
`default_nettype wire

// File: doc/lvl_states_arbiter.md
LVL_STATES_ARBITER -- requirements
Module: lvl_states_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH_LVL_STATES, default 11, meaning the lvl-state word width {dcd_bin, has_bkt}.
REQ-002 The block SHALL have parameter ADDR_WIDTH_LVL_STATES, default 9, meaning the lvl-state BRAM address width.
REQ-003 The block SHALL have parameter NUM_REQ, default 3, meaning the number of requesters, legal range 2..8.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- apply_i  in  NUM_REQ  per-requester hold request; level-sensitive, the same as the apply_find_o style.
- raddr_i  in  NUM_REQ*ADDR_WIDTH_LVL_STATES  packed read addresses, requester k in slice k.
- we_i  in  NUM_REQ  per-requester write enable.
- waddr_i  in  NUM_REQ*ADDR_WIDTH_LVL_STATES  packed write addresses.
- wdata_i  in  NUM_REQ*WIDTH_LVL_STATES  packed write data.
- grant_o  out  NUM_REQ  one-hot grant, registered.
- rdata_o  out  WIDTH_LVL_STATES  BRAM read data, broadcast to all requesters.
- ram_raddr_o  out  ADDR_WIDTH_LVL_STATES  BRAM read address.
- ram_rdata_i  in  WIDTH_LVL_STATES  BRAM read data, 1-cycle latency.
- ram_we_o  out  1  BRAM write enable.
- ram_waddr_o  out  ADDR_WIDTH_LVL_STATES  BRAM write address.
- ram_wdata_o  out  WIDTH_LVL_STATES  BRAM write data.
- init_done_o  out  1  BRAM contents valid; arbitration enabled.
- conflict_o  out  1  sticky flag: an ungranted requester drove a write.

Function
REQ-006 The state machine SHALL have three states: INIT, IDLE and GRANT.
REQ-007 From INIT, the FSM SHALL go to IDLE when the sweep completes, per REQ-016/017.
REQ-008 In IDLE with any apply_i bit set, the FSM SHALL go to GRANT.
- The winner is the first set bit searching upward, with wrap, from (last_winner+1) mod NUM_REQ.
- last_winner resets to NUM_REQ-1, so requester 0 wins the first arbitration.
REQ-009 grant_o SHALL assert in the cycle after the FSM enters GRANT, i.e. 1 cycle after apply_i is sampled in IDLE, and is registered.
REQ-010 In GRANT, the grant SHALL be held while apply_i[winner]=1, with no preemption.
REQ-011 When apply_i[winner]=0 in GRANT, the FSM SHALL return to IDLE and grant_o SHALL clear on the next edge.
- New arbitration starts from IDLE, so there is 1 dead cycle between owners.
REQ-012 While grant_o[k]=1, ram_raddr_o, ram_we_o, ram_waddr_o and ram_wdata_o SHALL combinationally equal requester k's slices.
REQ-013 While no grant is active and the FSM is not in INIT, ram_we_o SHALL be 0 and all ram addresses and wdata SHALL be 0.
REQ-014 rdata_o SHALL equal ram_rdata_i combinationally; the 1-cycle read latency is the requester's responsibility.
REQ-015 A write from an ungranted requester (we_i[j]=1 with grant_o[j]=0) SHALL be dropped and SHALL set conflict_o.
- conflict_o is cleared only by reset.
- apply_i rising in the same cycle as the write does not count as granted.

Reset
REQ-016 On reset assertion, immediately and including mid-GRANT:
- grant_o=0, ram_we_o=0, all addresses/wdata=0, conflict_o=0, init_done_o=0.
- last_winner=NUM_REQ-1, FSM=INIT.
- A sweep in progress restarts from address 0 after release.

Configuration
REQ-017 With LVL_STATES_INIT_SWEEP_EN defined, INIT SHALL write wdata=0 to addresses 0..2^ADDR_WIDTH_LVL_STATES-1.
- One address per cycle, ram_we_o=1, incrementing counter.
- Then IDLE; init_done_o=1 the cycle after the last write.
- apply_i is ignored throughout INIT, but ungranted writes still set conflict_o.
REQ-018 Without LVL_STATES_INIT_SWEEP_EN, INIT SHALL last exactly one cycle after reset release, with no writes, and init_done_o=1 on the following cycle.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding constants and the default widths WIDTH_LVL_STATES and ADDR_WIDTH_LVL_STATES.
REQ-020 The round-robin pick SHALL be one sub-module, rr_pick: combinational, with inputs req vector and last_winner, and outputs winner index and a valid flag.

Verification
REQ-021 The bench SHALL cover these directed scenarios (stimulus -> required response):
- With the sweep enabled and ADDR_WIDTH_LVL_STATES=4: release reset -> 16 writes of 0 to addresses 0..15 on consecutive cycles, then init_done_o=1; apply_i=3'b111 held during the sweep -> no grant until IDLE.
- After init, apply_i=3'b101 -> grant_o=3'b001; drop apply_i[0] -> grant clears, 1 dead cycle, then grant_o=3'b100.
- Requester 1 holds the grant with raddr=5 and ram holding 0x2A at address 5 -> ram_raddr_o=5 and rdata_o=0x2A one cycle later.
- Requester 1 granted, requester 2 drives we=1, waddr=7 -> ram_we_o reflects only requester 1, and conflict_o=1 and stays set.
- Assert rst mid-GRANT -> grant_o=0 and ram_we_o=0 asynchronously; after release the sweep restarts at address 0.
- With the macro undefined -> init_done_o=1 two cycles after reset release and no ram_we_o pulses.
